// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter: single register-file write port shared by execute and load.
// Load writebacks that lose arbitration wait in a small FIFO with WAW kill.
// Ports:
//   clk, rst            clock, async active-low reset
//   ex_we_i/waddr/wdata execute write; ex_stall_o holds it back
//   ld_valid_i/ready_o  load response handshake with ld_waddr_i/ld_wdata_i
//   we_o/waddr_o/wdata_o registered register-file write port
//   pend_o              registers with a live buffered load write
module regs_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_we_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  output logic        ex_stall_o,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  input  logic [4:0]  ld_waddr_i,
  input  logic [31:0] ld_wdata_i,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic [31:0] pend_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [SW-1:0] SC_LIM   = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] SC_ONE   = SW'(1);

  typedef enum logic [1:0] {
    WIN_NONE,
    WIN_EX,
    WIN_HEAD,
    WIN_LD
  } win_e;

  logic [4:0]       ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_live;

  logic [AW:0]      count;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [SW-1:0]    sc;

  logic             head_live;
  logic             head_dead;
  logic             starve;
  logic             ex_take;
  logic             ex_hit;
  logic             ld_acc;
  logic             ld_hit;
  win_e             win;
  logic             enq;
  logic             deq;

  logic [AW:0]      count_n;
  logic [DEPTH-1:0] live_n;
  logic [31:0]      pend_n;
  logic [SW-1:0]    sc_n;
  logic [4:0]       wa_n;
  logic [31:0]      wd_n;

  assign head_live  = (count != '0) && ent_live[rd_ptr];
  assign head_dead  = (count != '0) && !ent_live[rd_ptr];
  assign starve     = head_live && (sc == SC_LIM);
  assign ex_stall_o = starve && ex_we_i;
  assign ld_ready_o = (count != CNT_FULL);

  assign ex_take = ex_we_i && !ex_stall_o;
  assign ex_hit  = ex_take && (ex_waddr_i != 5'd0);
  assign ld_acc  = ld_valid_i && ld_ready_o;

  // A same-cycle load to the execute target is older; it is dropped.
  assign ld_hit = ld_acc && (ld_waddr_i != 5'd0) &&
                  !(ex_hit && (ld_waddr_i == ex_waddr_i));

  always_comb begin
    win = WIN_NONE;
    if (starve)
      win = WIN_HEAD;
    else if (ex_hit)
      win = WIN_EX;
    else if (head_live)
      win = WIN_HEAD;
    else if (ld_hit && (count == '0))
      win = WIN_LD;
  end

  // Dead heads leave without using the port.
  assign deq = (win == WIN_HEAD) || head_dead;
  assign enq = ld_hit && (win != WIN_LD);

  always_comb begin
    count_n = count;
    unique case ({enq, deq})
      2'b10:   count_n = count + CNT_ONE;
      2'b01:   count_n = count - CNT_ONE;
      default: count_n = count;
    endcase
  end

  always_comb begin
    live_n = ent_live;
    if (deq)
      live_n[rd_ptr] = 1'b0;
    if (ex_hit) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_addr[i] == ex_waddr_i)
          live_n[i] = 1'b0;
      end
    end
    if (enq)
      live_n[wr_ptr] = 1'b1;
  end

  always_comb begin
    pend_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_n[i]) begin
        if (enq && (wr_ptr == AW'(i)))
          pend_n[ld_waddr_i] = 1'b1;
        else
          pend_n[ent_addr[i]] = 1'b1;
      end
    end
    pend_n[0] = 1'b0;
  end

  always_comb begin
    sc_n = sc;
    if ((win == WIN_HEAD) || (count_n == '0))
      sc_n = '0;
    else if (head_live && (win == WIN_EX) && (sc != SC_LIM))
      sc_n = sc + SC_ONE;
  end

  always_comb begin
    wa_n = waddr_o;
    wd_n = wdata_o;
    unique case (win)
      WIN_EX: begin
        wa_n = ex_waddr_i;
        wd_n = ex_wdata_i;
      end
      WIN_HEAD: begin
        wa_n = ent_addr[rd_ptr];
        wd_n = ent_data[rd_ptr];
      end
      WIN_LD: begin
        wa_n = ld_waddr_i;
        wd_n = ld_wdata_i;
      end
      default: begin
        wa_n = waddr_o;
        wd_n = wdata_o;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      sc       <= '0;
      ent_live <= '0;
      pend_o   <= '0;
      we_o     <= 1'b0;
      waddr_o  <= '0;
      wdata_o  <= '0;
    end else begin
      count    <= count_n;
      sc       <= sc_n;
      ent_live <= live_n;
      pend_o   <= pend_n;
      we_o     <= (win != WIN_NONE);
      waddr_o  <= wa_n;
      wdata_o  <= wd_n;
      if (deq)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (enq)
        wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[wr_ptr] <= ld_waddr_i;
      ent_data[wr_ptr] <= ld_wdata_i;
    end
  end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// tb_regs_wb_arbiter: directed and random checks of regs_wb_arbiter
// against a queue-based writeback model.
module tb_regs_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIM   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_we_i = 1'b0;
  logic [4:0]  ex_waddr_i = '0;
  logic [31:0] ex_wdata_i = '0;
  logic        ex_stall_o;
  logic        ld_valid_i = 1'b0;
  logic        ld_ready_o;
  logic [4:0]  ld_waddr_i = '0;
  logic [31:0] ld_wdata_i = '0;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic [31:0] pend_o;

  always #5 clk = ~clk;

  regs_wb_arbiter #(
    .DEPTH(DEPTH),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ex_we_i(ex_we_i),
    .ex_waddr_i(ex_waddr_i),
    .ex_wdata_i(ex_wdata_i),
    .ex_stall_o(ex_stall_o),
    .ld_valid_i(ld_valid_i),
    .ld_ready_o(ld_ready_o),
    .ld_waddr_i(ld_waddr_i),
    .ld_wdata_i(ld_wdata_i),
    .we_o(we_o),
    .waddr_o(waddr_o),
    .wdata_o(wdata_o),
    .pend_o(pend_o)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        q[$];
  int          sc;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  int n_chk;
  int n_err;
  int n_stall;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_pend();
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < q.size(); i++)
      if (q[i].live) p[q[i].a] = 1'b1;
    return p;
  endfunction

  task automatic cyc(input logic ew, input logic [4:0] ea,
                     input logic [31:0] ed, input logic lv,
                     input logic [4:0] la, input logic [31:0] ldd);
    bit   hl, stv, stall, exw, ldw, ready, pop;
    int   win;
    ent_t e;
    @(negedge clk);
    ex_we_i    = ew;
    ex_waddr_i = ea;
    ex_wdata_i = ed;
    ld_valid_i = lv;
    ld_waddr_i = la;
    ld_wdata_i = ldd;
    #1;
    ready = (q.size() < DEPTH);
    hl    = (q.size() > 0) && q[0].live;
    stv   = hl && (sc == LIM);
    stall = stv && ew;
    check("ex_stall", ex_stall_o, stall);
    check("ld_ready", ld_ready_o, ready);
    if (ex_stall_o) n_stall++;
    exw = ew && !stall && (ea != 0);
    ldw = lv && ready && (la != 0) && !(exw && la == ea);
    win = 0;
    if (stv) win = 2;
    else if (exw) win = 1;
    else if (hl) win = 2;
    else if (ldw && q.size() == 0) win = 3;
    m_we = (win != 0);
    if (win == 1) begin
      m_wa = ea; m_wd = ed;
    end else if (win == 2) begin
      m_wa = q[0].a; m_wd = q[0].d;
    end else if (win == 3) begin
      m_wa = la; m_wd = ldd;
    end
    pop = (win == 2) || (q.size() > 0 && !q[0].live);
    if (pop) void'(q.pop_front());
    if (exw) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].a == ea) begin
          e = q[i];
          e.live = 1'b0;
          q[i] = e;
        end
      end
    end
    if (ldw && win != 3) begin
      e.a = la; e.d = ldd; e.live = 1'b1;
      q.push_back(e);
    end
    if (win == 2 || q.size() == 0) sc = 0;
    else if (hl && win == 1 && sc < LIM) sc++;
    @(posedge clk);
    #1;
    check("we", we_o, m_we);
    check("waddr", waddr_o, m_wa);
    check("wdata", wdata_o, m_wd);
    check("pend", pend_o, m_pend());
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic rst_checks(input string tag);
    check({tag, "_we"}, we_o, 0);
    check({tag, "_waddr"}, waddr_o, 0);
    check({tag, "_wdata"}, wdata_o, 0);
    check({tag, "_pend"}, pend_o, 0);
    check({tag, "_stall"}, ex_stall_o, 0);
    check({tag, "_ready"}, ld_ready_o, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b0;
    ex_we_i    = 1'b1;
    ex_waddr_i = 5'd6;
    ld_valid_i = 1'b0;
    #1;
    rst_checks("rst_async");
    q.delete();
    sc = 0; m_we = 0; m_wa = '0; m_wd = '0;
    @(posedge clk);
    #1;
    rst_checks("rst_hold");
    @(negedge clk);
    ex_we_i = 1'b0;
    rst     = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_err = 0; n_stall = 0;
    sc = 0; m_we = 0; m_wa = '0; m_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_checks("init");
    @(negedge clk);
    rst = 1'b1;

    cyc(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
    check("d_ex_we", we_o, 1);
    check("d_ex_waddr", waddr_o, 5);
    check("d_ex_wdata", wdata_o, 32'h11);
    check("d_ex_ready", ld_ready_o, 1);

    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA5);
    check("d_ft_waddr", waddr_o, 7);
    check("d_ft_wdata", wdata_o, 32'hA5);
    check("d_ft_pend", pend_o, 0);

    cyc(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
    check("d_cf_waddr1", waddr_o, 3);
    check("d_cf_pend9", pend_o[9], 1);
    idle();
    check("d_cf_waddr2", waddr_o, 9);
    check("d_cf_wdata2", wdata_o, 32'h99);
    check("d_cf_pend", pend_o, 0);

    cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'h44);
    check("d_waw_pend4", pend_o[4], 1);
    cyc(1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 32'd0);
    check("d_waw_kill", pend_o[4], 0);
    check("d_waw_data", wdata_o, 32'h22);
    idle();
    check("d_waw_nowr", we_o, 0);

    cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA0);
    cyc(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hB0);
    check("d_st_full", ld_ready_o, 0);
    n_stall = 0;
    for (int k = 0; k < 8; k++)
      cyc(1'b1, 5'(12 + k), 32'(k), 1'b0, 5'd0, 32'd0);
    check("d_st_count", n_stall, 1);
    repeat (4) idle();

    cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'hC0);
    cyc(1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'hC1);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle();
      check("d_rst_nowr", we_o, 0);
    end

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)),
            $urandom, $urandom_range(0, 99) < 60,
            5'($urandom_range(0, 7)), $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
